// File: rtl/reader_feed_ctrl_if.sv
// Reader feed sequencer bus: reader-side requests plus clutch/cam signals.
// master drives the reader and cam side, slave is the sequencer.
interface reader_feed_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             power;
    logic             sync_mode;
    logic [8:0]       cont_angle;
    logic [8:0]       clch_angle;
    logic             feed_req;
    logic             run_cont;
    logic             stop_req;
    logic             hopper_empty;
    logic             clch_latch;
    logic             engaged;
    logic             cycle_done;
    logic [CNT_W-1:0] card_count;
    logic [2:0]       pending;
    logic             hopper_fault;

    modport master (
        output power, sync_mode,
        output cont_angle, clch_angle,
        output feed_req, run_cont,
        output stop_req, hopper_empty,
        input  clch_latch, engaged,
        input  cycle_done, card_count,
        input  pending, hopper_fault
    );

    modport slave (
        input  power, sync_mode,
        input  cont_angle, clch_angle,
        input  feed_req, run_cont,
        input  stop_req, hopper_empty,
        output clch_latch, engaged,
        output cycle_done, card_count,
        output pending, hopper_fault
    );
endinterface

// File: rtl/reader_feed_ctrl.sv
// 1402 reader clutch sequencer: latches the clutch at legal cam
// points, counts revolutions and stops on a revolution boundary.
module reader_feed_ctrl #(
    parameter int PEND_MAX = 7,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    reader_feed_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ENGAGED,
        DROP,
        FAULT
    } state_t;

    localparam logic [2:0] PMAX = 3'(PEND_MAX);
    localparam logic [8:0] A75  = 9'd75;
    localparam logic [8:0] A195 = 9'd195;
    localparam logic [8:0] A314 = 9'd314;
    localparam logic [8:0] A315 = 9'd315;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       pend_q;
    logic [2:0]       pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             done_d;
    logic             lp;
    logic             eor;
    logic             demand;
    logic             more;
    logic             inc;
    logic             dec;
    logic             latch_o;
    logic             eng_o;
    logic             fault_o;

    assign lp = bus.power &&
                (bus.cont_angle == A315 ||
                 (!bus.sync_mode &&
                  (bus.cont_angle == A75 ||
                   bus.cont_angle == A195)));

    assign eor = bus.power && eng_o &&
                 bus.clch_angle == A314;

    assign demand = (pend_q != 3'd0) || bus.run_cont;
    assign inc    = bus.feed_req && (pend_q < PMAX);
    assign dec    = eor && !bus.run_cont &&
                    (pend_q != 3'd0);

    always_comb begin
        pend_d = pend_q;
        if (bus.stop_req)
            pend_d = 3'd0;
        else if (inc && !dec)
            pend_d = pend_q + 3'd1;
        else if (dec && !inc)
            pend_d = pend_q - 3'd1;
    end

    // Continuation sees the queue after this revolution's decrement.
    assign more = ((pend_d != 3'd0) || bus.run_cont) &&
                  !bus.stop_req && !bus.hopper_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 3'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_q + CNT_W'(done_d);
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (demand && !bus.stop_req) begin
                    if (bus.hopper_empty)
                        state_d = FAULT;
                    else if (bus.power)
                        state_d = ARM;
                end
            end
            ARM: begin
                if (bus.stop_req || bus.hopper_empty)
                    state_d = IDLE;
                else if (lp)
                    state_d = ENGAGED;
            end
            ENGAGED: begin
                if (eor) begin
                    done_d = 1'b1;
                    if (!more)
                        state_d = DROP;
                end
            end
            DROP: begin
                if (lp) begin
                    if (bus.hopper_empty && demand)
                        state_d = FAULT;
                    else
                        state_d = IDLE;
                end
            end
            FAULT: begin
                if (bus.stop_req && !bus.hopper_empty)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        latch_o = 1'b0;
        eng_o   = 1'b0;
        fault_o = 1'b0;
        unique case (state_q)
            ARM: latch_o = 1'b1;
            ENGAGED: begin
                latch_o = 1'b1;
                eng_o   = 1'b1;
            end
            DROP:  eng_o   = 1'b1;
            FAULT: fault_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.clch_latch   = latch_o;
    assign bus.engaged      = eng_o;
    assign bus.hopper_fault = fault_o;
    assign bus.cycle_done   = done_q;
    assign bus.card_count   = cnt_q;
    assign bus.pending      = pend_q;

endmodule

// File: tb/tb_reader_feed_ctrl.sv
// Bench for reader_feed_ctrl: cam plant, directed scenarios and a
// randomized run against a rule-level reference model.
module tb_reader_feed_ctrl;

    localparam int CNT_W = 16;
    localparam int PMAX  = 7;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DROP  = 3;
    localparam int M_FAULT = 4;

    logic clk = 1'b0;
    logic rst_n;

    reader_feed_ctrl_if #(.CNT_W(CNT_W)) bus ();

    reader_feed_ctrl #(
        .PEND_MAX(PMAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cang  = 0;
    int off   = 0;
    int m_ph  = M_IDLE;
    int m_pend = 0;
    int m_cnt  = 0;
    bit m_done = 1'b0;

    // clutch cam follows the continuous cam at a fixed phase offset
    task automatic drive_angles();
        bus.cont_angle = 9'(cang);
        bus.clch_angle = 9'((cang + off) % 360);
    endtask

    task automatic tick();
        bit lp, eor, dem, go, nd;
        int np, nph;
        lp = bus.power && (cang == 315 ||
             (!bus.sync_mode && (cang == 75 || cang == 195)));
        eor = bus.power && (m_ph == M_RUN || m_ph == M_DROP) &&
              ((cang + off) % 360 == 314);
        dem = (m_pend > 0) || bus.run_cont;
        np = m_pend;
        if (bus.feed_req && np < PMAX) np++;
        if (eor && !bus.run_cont && m_pend > 0) np--;
        if (bus.stop_req) np = 0;
        go = (np > 0 || bus.run_cont) &&
             !bus.stop_req && !bus.hopper_empty;
        nph = m_ph;
        nd = 1'b0;
        case (m_ph)
            M_IDLE:
                if (dem && !bus.stop_req) begin
                    if (bus.hopper_empty) nph = M_FAULT;
                    else if (bus.power) nph = M_ARM;
                end
            M_ARM:
                if (bus.stop_req || bus.hopper_empty) nph = M_IDLE;
                else if (lp) nph = M_RUN;
            M_RUN:
                if (eor) begin
                    nd = 1'b1;
                    nph = go ? M_RUN : M_DROP;
                end
            M_DROP:
                if (lp)
                    nph = (bus.hopper_empty && dem) ? M_FAULT : M_IDLE;
            default:
                if (bus.stop_req && !bus.hopper_empty) nph = M_IDLE;
        endcase
        @(posedge clk);
        m_ph = nph;
        m_pend = np;
        m_done = nd;
        if (nd) m_cnt = (m_cnt + 1) % 65536;
        #1;
        if (bus.power) cang = (cang + 1) % 360;
        drive_angles();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_ph = M_IDLE;
        m_pend = 0;
        m_cnt = 0;
        m_done = 1'b0;
        bus.power = 1'b0;
        bus.feed_req = 1'b0;
        bus.run_cont = 1'b0;
        bus.stop_req = 1'b0;
        bus.hopper_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.clch_latch !== 1'b0) begin n_bad++;
            $display("FAIL reset latch: got %b want 0", bus.clch_latch); end
        n_cmp++; if (bus.engaged !== 1'b0) begin n_bad++;
            $display("FAIL reset engaged: got %b want 0", bus.engaged); end
        n_cmp++; if (bus.cycle_done !== 1'b0) begin n_bad++;
            $display("FAIL reset done: got %b want 0", bus.cycle_done); end
        n_cmp++; if (bus.card_count !== 16'd0) begin n_bad++;
            $display("FAIL reset count: got %0d want 0", bus.card_count); end
        n_cmp++; if (bus.pending !== 3'd0) begin n_bad++;
            $display("FAIL reset pending: got %0d want 0", bus.pending); end
        n_cmp++; if (bus.hopper_fault !== 1'b0) begin n_bad++;
            $display("FAIL reset fault: got %b want 0", bus.hopper_fault); end
    endtask

    task automatic test_single();
        int dones = 0, eng_ang = -1, done_ang = -1;
        int t_done = -1, t_idle = -1;
        bit arm_seen = 1'b0, drop_seen = 1'b0;
        do_reset();
        bus.sync_mode = 1'b1; bus.power = 1'b1;
        off = 0; cang = 300; drive_angles();
        bus.feed_req = 1'b1; tick(); bus.feed_req = 1'b0;
        for (int t = 0; t < 800 && t_idle < 0; t++) begin
            tick();
            if (bus.clch_latch && !bus.engaged) arm_seen = 1'b1;
            if (bus.engaged && eng_ang < 0) eng_ang = cang;
            if (bus.cycle_done) begin
                dones++; done_ang = cang; t_done = t;
                drop_seen = bus.engaged && !bus.clch_latch;
            end
            if (dones > 0 && !bus.engaged) t_idle = t;
        end
        n_cmp++; if (!arm_seen) begin n_bad++;
            $display("FAIL single arm: got 0 want 1"); end
        n_cmp++; if (eng_ang != 316) begin n_bad++;
            $display("FAIL single engage angle: got %0d want 316", eng_ang); end
        n_cmp++; if (dones != 1) begin n_bad++;
            $display("FAIL single dones: got %0d want 1", dones); end
        n_cmp++; if (done_ang != 315) begin n_bad++;
            $display("FAIL single eor angle: got %0d want 315", done_ang); end
        n_cmp++; if (!drop_seen) begin n_bad++;
            $display("FAIL single drop: got 0 want 1"); end
        n_cmp++; if (t_idle - t_done != 1) begin n_bad++;
            $display("FAIL single idle gap: got %0d want 1", t_idle - t_done); end
        n_cmp++; if (bus.card_count !== 16'd1) begin n_bad++;
            $display("FAIL single count: got %0d want 1", bus.card_count); end
        n_cmp++; if (bus.pending !== 3'd0) begin n_bad++;
            $display("FAIL single pending: got %0d want 0", bus.pending); end
    endtask

    task automatic test_nonsync();
        int dones = 0, eng_ang = -1, done_ang = -1;
        do_reset();
        bus.sync_mode = 1'b0; bus.power = 1'b1;
        off = 240; cang = 60; drive_angles();
        bus.feed_req = 1'b1; tick(); bus.feed_req = 1'b0;
        for (int t = 0; t < 1200; t++) begin
            tick();
            if (bus.engaged && eng_ang < 0) eng_ang = cang;
            if (bus.cycle_done) begin dones++; done_ang = cang; end
        end
        n_cmp++; if (eng_ang != 76) begin n_bad++;
            $display("FAIL nonsync engage angle: got %0d want 76", eng_ang); end
        n_cmp++; if (done_ang != 75) begin n_bad++;
            $display("FAIL nonsync eor angle: got %0d want 75", done_ang); end
        n_cmp++; if (dones != 1) begin n_bad++;
            $display("FAIL nonsync dones: got %0d want 1", dones); end
        n_cmp++; if (bus.engaged !== 1'b0) begin n_bad++;
            $display("FAIL nonsync engaged: got %b want 0", bus.engaged); end
        bus.sync_mode = 1'b1; off = 0; drive_angles();
    endtask

    task automatic test_back_to_back();
        int dones = 0, k = 0;
        int td[4];
        bit started = 1'b0, gap = 1'b0;
        do_reset();
        bus.sync_mode = 1'b1; bus.power = 1'b1;
        off = 0; cang = 300; drive_angles();
        bus.feed_req = 1'b1;
        repeat (3) tick();
        bus.feed_req = 1'b0;
        n_cmp++; if (bus.pending !== 3'd3) begin n_bad++;
            $display("FAIL b2b queued: got %0d want 3", bus.pending); end
        for (int t = 0; t < 1900; t++) begin
            bus.feed_req = started && (k == 50);
            tick();
            if (started) k++;
            if (bus.engaged) started = 1'b1;
            if (bus.cycle_done) begin
                if (dones < 4) td[dones] = t;
                dones++;
            end
            if (started && dones < 4 && !bus.clch_latch) gap = 1'b1;
            if (dones >= 4 && !bus.engaged) break;
        end
        bus.feed_req = 1'b0;
        n_cmp++; if (dones != 4) begin n_bad++;
            $display("FAIL b2b dones: got %0d want 4", dones); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (dones >= 4 && td[i] - td[i-1] != 360) begin n_bad++;
                $display("FAIL b2b spacing %0d: got %0d want 360",
                         i, td[i] - td[i-1]); end
        end
        n_cmp++; if (gap) begin n_bad++;
            $display("FAIL b2b latch gap: got 1 want 0"); end
        n_cmp++; if (bus.card_count !== 16'd4) begin n_bad++;
            $display("FAIL b2b count: got %0d want 4", bus.card_count); end
        n_cmp++; if (bus.pending !== 3'd0) begin n_bad++;
            $display("FAIL b2b pending: got %0d want 0", bus.pending); end
    endtask

    task automatic test_pend_sat();
        int dones = 0;
        bit seen = 1'b0;
        do_reset();
        bus.sync_mode = 1'b1; off = 0; cang = 10; drive_angles();
        bus.feed_req = 1'b1;
        repeat (9) tick();
        bus.feed_req = 1'b0;
        n_cmp++; if (bus.pending !== 3'd7) begin n_bad++;
            $display("FAIL sat pending: got %0d want 7", bus.pending); end
        n_cmp++; if (bus.clch_latch !== 1'b0) begin n_bad++;
            $display("FAIL sat unpowered latch: got %b want 0", bus.clch_latch); end
        bus.power = 1'b1;
        for (int t = 0; t < 1200 && dones < 2; t++) begin
            tick();
            if (bus.cycle_done) dones++;
        end
        n_cmp++; if (bus.pending !== 3'd5) begin n_bad++;
            $display("FAIL sat drained: got %0d want 5", bus.pending); end
        for (int t = 0; t < 400 && !seen; t++) begin
            bus.feed_req = bus.engaged && (bus.clch_angle == 9'd314);
            tick();
            seen = bus.cycle_done;
        end
        bus.feed_req = 1'b0;
        n_cmp++; if (!seen || bus.pending !== 3'd5) begin n_bad++;
            $display("FAIL sat feed at eor: got %0d want 5", bus.pending); end
        bus.stop_req = 1'b1;
        for (int t = 0; t < 500; t++) begin
            tick();
            if (!bus.engaged && !bus.clch_latch) break;
        end
        bus.stop_req = 1'b0;
        n_cmp++; if (bus.pending !== 3'd0 || bus.engaged !== 1'b0) begin
            n_bad++;
            $display("FAIL sat flush: got pend %0d eng %b want 0 0",
                     bus.pending, bus.engaged); end
    endtask

    task automatic test_stop();
        int dones = 0;
        bit drop_seen = 1'b0;
        do_reset();
        bus.sync_mode = 1'b1; bus.power = 1'b1;
        off = 0; cang = 300; drive_angles();
        bus.run_cont = 1'b1;
        for (int t = 0; t < 100 && !bus.engaged; t++) tick();
        for (int t = 0; t < 400 && bus.clch_angle != 9'd100; t++) tick();
        bus.stop_req = 1'b1;
        for (int t = 0; t < 900; t++) begin
            tick();
            if (bus.cycle_done) begin
                dones++;
                drop_seen = bus.engaged && !bus.clch_latch;
            end
        end
        n_cmp++; if (dones != 1) begin n_bad++;
            $display("FAIL stop dones: got %0d want 1", dones); end
        n_cmp++; if (!drop_seen) begin n_bad++;
            $display("FAIL stop drop: got 0 want 1"); end
        n_cmp++; if (bus.card_count !== 16'd1) begin n_bad++;
            $display("FAIL stop count: got %0d want 1", bus.card_count); end
        n_cmp++; if (bus.pending !== 3'd0 || bus.engaged !== 1'b0) begin
            n_bad++;
            $display("FAIL stop idle: got pend %0d eng %b want 0 0",
                     bus.pending, bus.engaged); end
        bus.run_cont = 1'b0;
        bus.stop_req = 1'b0;
    endtask

    task automatic test_fault();
        do_reset();
        bus.power = 1'b1; bus.hopper_empty = 1'b1;
        bus.feed_req = 1'b1; tick(); bus.feed_req = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.hopper_fault !== 1'b1) begin n_bad++;
            $display("FAIL fault set: got %b want 1", bus.hopper_fault); end
        n_cmp++; if (bus.clch_latch !== 1'b0) begin n_bad++;
            $display("FAIL fault latch: got %b want 0", bus.clch_latch); end
        bus.hopper_empty = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.hopper_fault !== 1'b1) begin n_bad++;
            $display("FAIL fault sticky: got %b want 1", bus.hopper_fault); end
        bus.stop_req = 1'b1; tick(); bus.stop_req = 1'b0;
        n_cmp++; if (bus.hopper_fault !== 1'b0) begin n_bad++;
            $display("FAIL fault clear: got %b want 0", bus.hopper_fault); end
        n_cmp++; if (bus.pending !== 3'd0) begin n_bad++;
            $display("FAIL fault pending: got %0d want 0", bus.pending); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        do_reset();
        bus.sync_mode = 1'b1; bus.power = 1'b1;
        off = 0; cang = 300; drive_angles();
        bus.feed_req = 1'b1; repeat (2) tick(); bus.feed_req = 1'b0;
        for (int t = 0; t < 1100; t++) begin
            tick();
            if (bus.cycle_done) dones++;
            if (dones > 0 && bus.engaged && bus.clch_angle == 9'd200) break;
        end
        n_cmp++; if (bus.card_count !== 16'd1 || bus.pending !== 3'd1) begin
            n_bad++;
            $display("FAIL midrev setup: got cnt %0d pend %0d want 1 1",
                     bus.card_count, bus.pending); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.clch_latch !== 1'b0 || bus.engaged !== 1'b0) begin
            n_bad++;
            $display("FAIL midrev outputs: got latch %b eng %b want 0 0",
                     bus.clch_latch, bus.engaged); end
        n_cmp++; if (bus.pending !== 3'd0 || bus.card_count !== 16'd0) begin
            n_bad++;
            $display("FAIL midrev counters: got pend %0d cnt %0d want 0 0",
                     bus.pending, bus.card_count); end
        do_reset();
        tick();
        n_cmp++; if (bus.clch_latch !== 1'b0) begin n_bad++;
            $display("FAIL midrev idle: got %b want 0", bus.clch_latch); end
    endtask

    task automatic test_random();
        do_reset();
        bus.sync_mode = 1'b1; off = 0;
        cang = $urandom_range(0, 359); drive_angles();
        for (int t = 0; t < 6000; t++) begin
            bus.power = ($urandom_range(0, 7) != 0);
            bus.feed_req = ($urandom_range(0, 5) == 0);
            bus.stop_req = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) bus.run_cont = !bus.run_cont;
            if ($urandom_range(0, 399) == 0)
                bus.hopper_empty = !bus.hopper_empty;
            tick();
            n_cmp++;
            if (bus.clch_latch !== (m_ph == M_ARM || m_ph == M_RUN)) begin
                n_bad++;
                $display("FAIL rand latch t=%0d: got %b", t, bus.clch_latch); end
            n_cmp++;
            if (bus.engaged !== (m_ph == M_RUN || m_ph == M_DROP)) begin
                n_bad++;
                $display("FAIL rand engaged t=%0d: got %b", t, bus.engaged); end
            n_cmp++;
            if (bus.hopper_fault !== (m_ph == M_FAULT)) begin
                n_bad++;
                $display("FAIL rand fault t=%0d: got %b", t, bus.hopper_fault); end
            n_cmp++;
            if (bus.cycle_done !== m_done) begin n_bad++;
                $display("FAIL rand done t=%0d: got %b want %b",
                         t, bus.cycle_done, m_done); end
            n_cmp++;
            if (bus.pending !== 3'(m_pend)) begin n_bad++;
                $display("FAIL rand pending t=%0d: got %0d want %0d",
                         t, bus.pending, m_pend); end
            n_cmp++;
            if (bus.card_count !== 16'(m_cnt)) begin n_bad++;
                $display("FAIL rand count t=%0d: got %0d want %0d",
                         t, bus.card_count, m_cnt); end
        end
        bus.run_cont = 1'b0;
        bus.hopper_empty = 1'b0;
        bus.stop_req = 1'b0;
        bus.feed_req = 1'b0;
    endtask

    initial begin
        bus.power = 1'b0;
        bus.sync_mode = 1'b1;
        bus.feed_req = 1'b0;
        bus.run_cont = 1'b0;
        bus.stop_req = 1'b0;
        bus.hopper_empty = 1'b0;
        drive_angles();
        test_reset();
        test_single();
        test_nonsync();
        test_back_to_back();
        test_pend_sat();
        test_stop();
        test_fault();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reader_feed_ctrl.md
Name: reader_feed_ctrl

Overview:
Sequences the 1402 reader clutch. Accepts single-card feed requests and a continuous-run level, then drives the clutch latch magnet at legal latch points of the continuous cam angle. Counts completed clutch revolutions and stops cleanly at a revolution boundary on demand exhaustion, stop, or hopper empty. Sits between reader control logic and the clutch/cam assembly, consuming its continuous and clutch angle outputs.

Parameters:
PEND_MAX, 7, maximum queued single-feed requests; the pending counter saturates here.
CNT_W, 16, width of card_count.

Ports:
clk  in  1  model clock; one degree of cam rotation per clk when power=1.
rst_n  in  1  asynchronous, active-low reset.
power  in  1  motor running; angles advance only when high.
sync_mode  in  1  1 = latch only at 315; 0 = latch at 75, 195 or 315.
cont_angle  in  9  continuous cam angle, 0..359.
clch_angle  in  9  clutch cam angle, 0..359; starts at 315 on engagement.
feed_req  in  1  one-clk pulse; queues one feed cycle.
run_cont  in  1  level; feed continuously while high.
stop_req  in  1  level; finish the current revolution, then stop and flush the queue.
hopper_empty  in  1  no cards in hopper.
clch_latch  out  1  latch magnet drive to the clutch assembly.
engaged  out  1  clutch is revolving under control of this block.
cycle_done  out  1  one-clk pulse at the end of each revolution.
card_count  out  CNT_W  completed revolutions; wraps modulo 2^CNT_W.
pending  out  3  queued single-feed requests.
hopper_fault  out  1  sticky; demand existed while the hopper was empty.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 immediately, including clch_latch mid-revolution. pending=0, card_count=0.
- lp (latch point) = power && (cont_angle==315 || (!sync_mode && (cont_angle==75 || cont_angle==195))).
- eor (end of revolution) = power && engaged && clch_angle==314.
- demand = pending!=0 || run_cont.
- pending update, each clk: +1 on feed_req if below PEND_MAX; -1 at eor when run_cont=0 and pending!=0.
  - Simultaneous +1 and -1: net 0.
  - Request at PEND_MAX: dropped.
  - stop_req=1: pending forced to 0 and feed_req ignored.
- States:
  - IDLE: clch_latch=0, engaged=0.
    - demand && !stop_req && hopper_empty -> FAULT.
    - demand && !stop_req && !hopper_empty && power -> ARM.
  - ARM: clch_latch=1.
    - lp -> ENGAGED; engaged=1 from the next clk.
    - stop_req or hopper_empty before lp -> IDLE, clch_latch=0 next clk.
  - ENGAGED: clch_latch=1, engaged=1. At eor:
    - cycle_done=1 for that clk; card_count+1.
    - Evaluate continuation with pending already decremented for this eor: if demand && !stop_req && !hopper_empty, stay ENGAGED. This is back-to-back feeding with no lost revolution.
    - Otherwise clch_latch=0 from the next clk; go to DROP.
  - DROP: clch_latch=0, engaged=1 until the next lp. On lp, go to FAULT if hopper_empty && demand at that clk, else IDLE.
  - FAULT: clch_latch=0, engaged=0, hopper_fault=1. Leave to IDLE only when stop_req=1 && hopper_empty=0; hopper_fault clears on that exit.
- power=0: angles freeze, so lp and eor are false. State, counters and clch_latch all hold.
- stop_req never truncates a revolution once ENGAGED.
- cycle_done pulses only in ENGAGED at eor, never in DROP.
- Outputs are registered. State changes take effect the clk after the qualifying condition.

Test Plan:
- Single feed, sync_mode=1, power=1, cont_angle=300, one feed_req -> ARM; enters ENGAGED after cont_angle=315. One cycle_done at clch_angle=314. card_count=1, pending=0. clch_latch low after eor; IDLE after the next 315.
- Non-sync, cont_angle=60, one feed_req -> engages at the 75 latch point, not 195 or 315. Exactly one revolution, then stop.
- Three feed_req pulses, then one more during the first revolution -> four consecutive cycle_done pulses 360 clk apart, with no gap revolution. card_count=4; clch_latch stays 1 until the 4th eor.
- PEND_MAX=7, 9 feed_req pulses while IDLE with power=0 -> pending=7. With feed_req and eor in the same clk, pending stays unchanged.
- run_cont=1 with stop_req asserted at clch_angle=100 -> the current revolution completes. cycle_done once more, pending=0, DROP then IDLE; no further revolutions.
- hopper_empty=1 with feed_req -> FAULT, hopper_fault=1, clch_latch=0. Then hopper_empty=0 and stop_req=1 -> IDLE, hopper_fault=0.
- rst_n low mid-revolution (clch_angle=200) -> clch_latch, engaged, pending and card_count are 0 immediately, state IDLE.
